// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the board-input conditioner.
// The counter width helper is used by each debounce channel.
package input_conditioner_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int DEBOUNCE_MIN    = 2;

    // Width that can hold 0 .. cycles-1; never less than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel conditioner: synchroniser chain, stability counter, stable level.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from first sampling edge to q_o.
// No backpressure; rise_o/fall_o are registered strobes on the edge that updates q_o.
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic raw_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt;
        logic                   q;
    } ch_state_t;

    ch_state_t st;
    ch_state_t st_nxt;
    logic      rise_nxt;
    logic      fall_nxt;
    logic      rise_q;
    logic      fall_q;
    logic      s;

    assign s = st.sync[SYNC_STAGES-1];

    // The counter stops at CNT_TERM: reaching it commits the level and clears the count.
    always_comb begin
        st_nxt      = st;
        rise_nxt    = 1'b0;
        fall_nxt    = 1'b0;
        st_nxt.sync = {st.sync[SYNC_STAGES-2:0], raw_i};
        if (s == st.q) begin
            st_nxt.cnt = '0;
        end else if (st.cnt == CNT_TERM) begin
            st_nxt.q   = s;
            st_nxt.cnt = '0;
            rise_nxt   = s;
            fall_nxt   = ~s;
        end else begin
            st_nxt.cnt = st.cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            st     <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            st     <= st_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    assign q_o    = st.q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: synchronises and debounces BTNC and the slide switches.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles per channel; no backpressure, pulses are one cycle.
// Channel 0 is the button, channels 1..NUM_SW are the switches.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              btn_i,
    input  logic [NUM_SW-1:0] sw_i,
    output logic              btn_level_o,
    output logic              btn_rise_o,
    output logic [NUM_SW-1:0] sw_o,
    output logic              sw_change_o
);

    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_chk_db
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= %0d", DEBOUNCE_MIN);
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_chk_sync
        $error("input_conditioner: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    logic [NUM_SW:0] ch_raw;
    logic [NUM_SW:0] ch_q;
    logic [NUM_SW:0] ch_rise;
    logic [NUM_SW:0] ch_fall;

    assign ch_raw = {sw_i, btn_i};

    for (genvar i = 0; i <= NUM_SW; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .raw_i    (ch_raw[i]),
            .q_o      (ch_q[i]),
            .rise_o   (ch_rise[i]),
            .fall_o   (ch_fall[i])
        );
    end

    assign btn_level_o = ch_q[0];
    // Rise and fall of one channel are mutually exclusive, so the mask never hides a press.
    assign btn_rise_o  = ch_rise[0] & ~ch_fall[0];
    assign sw_o        = ch_q[NUM_SW:1];
    // Several bits committing on one edge merge into a single change pulse.
    assign sw_change_o = |(ch_rise[NUM_SW:1] | ch_fall[NUM_SW:1]);

endmodule
